// File: rtl/uart_mem_arb.sv
// Round-robin arbiter that shares the single-port UART frame RAM between the
// RX byte writer (requester 0) and the TX readback reader (requester 1).
module uart_mem_arb #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_mem_en,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    typedef enum logic {
        OWNER_WR = 1'b0,
        OWNER_RD = 1'b1
    } owner_e;

    owner_e            last_r;
    owner_e            last_nxt_s;
    logic              wr_elig_s;
    logic              rd_elig_s;
    logic              wr_gnt_s;
    logic              rd_gnt_s;
    logic              conflict_s;
    logic [RD_LAT-1:0] rd_tag_r;
    logic [RD_LAT-1:0] rd_tag_nxt_s;

    // A requester whose ack is showing was granted last cycle and sits this one out
    always_comb begin
        wr_elig_s = i_wr_req & ~o_wr_ack;
        rd_elig_s = i_rd_req & ~o_rd_ack;
    end

    // Grant selection; the pointer only moves when both compete
    always_comb begin
        wr_gnt_s   = 1'b0;
        rd_gnt_s   = 1'b0;
        last_nxt_s = last_r;
        case ({wr_elig_s, rd_elig_s})
            2'b10: wr_gnt_s = 1'b1;
            2'b01: rd_gnt_s = 1'b1;
            2'b11: begin
                if (last_r == OWNER_RD) begin
                    wr_gnt_s   = 1'b1;
                    last_nxt_s = OWNER_WR;
                end else begin
                    rd_gnt_s   = 1'b1;
                    last_nxt_s = OWNER_RD;
                end
            end
            default: begin
                wr_gnt_s = 1'b0;
                rd_gnt_s = 1'b0;
            end
        endcase
    end

    // Contention: both asking, only one served
    always_comb begin
        conflict_s = i_wr_req & i_rd_req & (wr_gnt_s ^ rd_gnt_s);
    end

    // Next value of the read tag pipe; stage 0 is loaded from the read command cycle
    always_comb begin
        rd_tag_nxt_s    = '0;
        rd_tag_nxt_s[0] = o_rd_ack;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_tag_nxt_s[i] = rd_tag_r[i-1];
        end
    end

    // Memory port and acks, driven one cycle after the grant decision
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_wr_ack    <= 1'b0;
            o_rd_ack    <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            last_r      <= OWNER_RD;
        end else begin
            o_wr_ack  <= wr_gnt_s;
            o_rd_ack  <= rd_gnt_s;
            o_mem_en  <= wr_gnt_s | rd_gnt_s;
            o_mem_wen <= wr_gnt_s;
            last_r    <= last_nxt_s;
            if (wr_gnt_s) begin
                o_mem_addr  <= i_wr_addr;
                o_mem_wdata <= i_wr_data;
            end else if (rd_gnt_s) begin
                o_mem_addr <= i_rd_addr;
            end
        end
    end

    // Read return: tag pipe tracks BRAM latency, data captured when the tag emerges
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_tag_r   <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            rd_tag_r   <= rd_tag_nxt_s;
            o_rd_valid <= rd_tag_r[RD_LAT-1];
            if (rd_tag_r[RD_LAT-1]) begin
                o_rd_data <= i_mem_rdata;
            end
        end
    end

    // Saturating contention counter
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_conflict_cnt <= '0;
        end else if (conflict_s && (o_conflict_cnt != {CNT_W{1'b1}})) begin
            o_conflict_cnt <= o_conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/uart_mem_arb.md
Name: uart_mem_arb

Overview:
- Two-requester arbiter for the single-port UART frame RAM (ADDR_W x DATA_W BRAM).
- Requester 0 is the RX byte writer; requester 1 is the TX readback reader.
- Shares the one memory port using round-robin, with a req/ack handshake per requester.
- Tracks read latency and returns read data with a valid strobe.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 2, BRAM read latency in cycles from command cycle to i_mem_rdata valid; legal 1..4.
- CNT_W, 16, width of the conflict counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_wr_req  in  1  write request, held until o_wr_ack
- i_wr_addr  in  ADDR_W  write address, stable while i_wr_req
- i_wr_data  in  DATA_W  write data, stable while i_wr_req
- o_wr_ack  out  1  one-cycle pulse: write issued to memory this cycle
- i_rd_req  in  1  read request, held until o_rd_ack
- i_rd_addr  in  ADDR_W  read address, stable while i_rd_req
- o_rd_ack  out  1  one-cycle pulse: read issued to memory this cycle
- o_rd_valid  out  1  one-cycle pulse: o_rd_data holds returned read data
- o_rd_data  out  DATA_W  read data
- o_mem_en  out  1  memory enable
- o_mem_wen  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_rdata  in  DATA_W  memory read data
- o_conflict_cnt  out  CNT_W  saturating count of contention cycles

Behaviour:
- Reset (i_reset low, asynchronous):
  - All outputs 0.
  - Read-latency pipe cleared.
  - Round-robin pointer r_last = 1 (read), so the write wins the first contention.
- Arbitration runs every cycle on sampled requests.
  - Eligible = req high AND requester not granted in the previous cycle. The mask blocks re-grant of a request the requester has not yet dropped.
  - One eligible requester: grant it.
  - Both eligible: grant the one != r_last; r_last <= granted id.
  - None eligible: no grant.
- Grant latency is one cycle. A grant decided in cycle N drives, in cycle N+1 (all registered):
  - o_mem_en = 1 and the matching ack = 1.
  - o_mem_wen = 1 for a write, 0 for a read.
  - o_mem_addr = granted address; o_mem_wdata = i_wr_data for a write.
- No-grant cycles: o_mem_en = 0, o_mem_wen = 0; o_mem_addr/o_mem_wdata hold their last values.
- Requester rules:
  - Drops req, or presents the next request, in the cycle after its ack.
  - The 1-cycle eligibility mask ensures no double issue even when req stays high through the ack cycle.
- Throughput:
  - Per requester: max one access every 2 cycles.
  - Aggregate: one access per cycle when both requesters are active (alternating).
- Read return:
  - Read command in cycle C → i_mem_rdata sampled at cycle C+RD_LAT.
  - o_rd_data registered and o_rd_valid = 1 in cycle C+RD_LAT+1.
  - Shift-register tag pipe of depth RD_LAT+1, so back-to-back reads return in order with no loss.
- o_conflict_cnt:
  - Increments by 1 in each cycle where i_wr_req and i_rd_req are both high and exactly one is granted.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset mid-operation: in-flight reads are discarded. No o_rd_valid may appear after reset release for commands issued before reset.
- The block does not check address ranges or RAW hazards. Writes and reads to the same address are serviced in grant order.

Test Plan:
- Reset release, then wr_req addr=0x005 data=0xA5 held → o_wr_ack and o_mem_en=1, wen=1, addr=0x005, wdata=0xA5 exactly 1 cycle after req; no second ack while req stays high 1 extra cycle.
- Write 0x3C to addr 0x010, then rd_req addr=0x010 (RAM model RD_LAT=2) → o_rd_ack, then o_rd_valid with o_rd_data=0x3C 3 cycles after o_rd_ack.
- wr_req and rd_req asserted together, both held 6 cycles, new addr each ack → grants alternate W,R,W,R,... starting with W; o_conflict_cnt increments only on cycles where one requester waited; mem port busy every cycle after first.
- Reads back-to-back every 2 cycles to addrs 0..7 preloaded with 0x10..0x17 → 8 o_rd_valid pulses, data 0x10..0x17 in order, each RD_LAT+1 after its command.
- Assert i_reset low 1 cycle after a read ack → all outputs 0 immediately; after release, no o_rd_valid for the aborted read; next contention grants write first.
- CNT_W=4 override, hold both reqs 40 cycles → o_conflict_cnt stops at 15.
